sym_deframer: RTL and testbench

//  Sits directly downstream of the 4-stage 2-bit symbol delay buffer and consumes its output stream.

---
 rtl/sym_pkg.sv | 20 ++
 rtl/sym_fifo.sv | 61 ++++++
 rtl/sym_deframer.sv | 152 +++++++++++++++
 tb/tb_sym_deframer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sym_pkg.sv
// Shared symbol codes and FSM state type for the symbol deframer.
// Used by sym_deframer; parity option is selected there via SYM_DEFRAMER_PARITY_EN.
package sym_pkg;

    localparam logic [1:0] SYM_IDLE = 2'b00;
    localparam logic [1:0] SYM_RSVD = 2'b01;
    localparam logic [1:0] SYM_D0   = 2'b10;
    localparam logic [1:0] SYM_D1   = 2'b11;

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } dfr_state_e;

    // The MSB of a line symbol marks it as carrying a data bit in its LSB.
    function automatic logic sym_is_data(input logic [1:0] sym);
        return sym[1];
    endfunction

endpackage

// File: rtl/sym_fifo.sv
// DATA_W x DEPTH synchronous FIFO with first-word-fall-through head output.
// A push into a full FIFO is accepted when a pop happens on the same edge.
module sym_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [DATA_W-1:0]            push_data_i,
    input  logic                         pop_i,
    output logic [DATA_W-1:0]            head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   fill_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              push_ok;
    logic              pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign fill_o  = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    // When full, the slot being written is the one freed by the concurrent pop.
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sym_deframer.sv
// Decodes 2-bit line symbols into LSB-first words, queues them, flags framing errors and overflow.
// Define SYM_DEFRAMER_PARITY_EN to expect an even-parity symbol after each word's data bits.
//
//  state   | meaning
//  HUNT    | no partial word; waiting for first data symbol
//  COLLECT | bits 1..N-1 of a word being assembled
module sym_deframer
    import sym_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int IDLE_TIMEOUT = 15
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [1:0]                        in,
    output logic [DATA_W-1:0]                 out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fill,
    output logic                              frame_err,
    output logic                              overflow
);

`ifdef SYM_DEFRAMER_PARITY_EN
    localparam int N = DATA_W + 1;
`else
    localparam int N = DATA_W;
`endif
    localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    dfr_state_e        state_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [IDLE_W-1:0] idle_cnt_q;
    logic [DATA_W-1:0] word_q;
    logic              frame_err_q;
    logic              overflow_q;

    logic              sym_data;
    logic              sym_bit;
    logic              sym_rsvd;
    logic              last_sym;
    logic              par_ok;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] word_ins;
    logic [DATA_W-1:0] complete_word;

    assign sym_data = sym_is_data(in);
    assign sym_bit  = in[0];
    assign sym_rsvd = (in == SYM_RSVD);
    assign last_sym = (state_q == COLLECT) && sym_data && (bit_cnt_q == CNT_W'(N - 1));

    always_comb begin
        word_ins = word_q;
        for (int i = 0; i < DATA_W; i++) begin
            if (bit_cnt_q == CNT_W'(i)) begin
                word_ins[i] = sym_bit;
            end
        end
    end

`ifdef SYM_DEFRAMER_PARITY_EN
    // Final symbol is the parity bit; data bits are already all in word_q.
    assign par_ok        = (sym_bit == ^word_q);
    assign complete_word = word_q;
`else
    assign par_ok        = 1'b1;
    assign complete_word = word_ins;
`endif

    assign push      = last_sym && par_ok;
    assign pop       = out_valid && out_ready;
    assign out_valid = !fifo_empty;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= HUNT;
            bit_cnt_q   <= '0;
            idle_cnt_q  <= '0;
            word_q      <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (push && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                HUNT: begin
                    idle_cnt_q <= '0;
                    if (sym_data) begin
                        word_q    <= DATA_W'(sym_bit);
                        bit_cnt_q <= CNT_W'(1);
                        state_q   <= COLLECT;
                    end else if (sym_rsvd) begin
                        frame_err_q <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (sym_data) begin
                        idle_cnt_q <= '0;
                        if (last_sym) begin
                            frame_err_q <= !par_ok;
                            bit_cnt_q   <= '0;
                            state_q     <= HUNT;
                        end else begin
                            word_q    <= word_ins;
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else if (sym_rsvd) begin
                        frame_err_q <= 1'b1;
                        bit_cnt_q   <= '0;
                        idle_cnt_q  <= '0;
                        state_q     <= HUNT;
                    end else if (idle_cnt_q == IDLE_W'(IDLE_TIMEOUT - 1)) begin
                        frame_err_q <= 1'b1;
                        bit_cnt_q   <= '0;
                        idle_cnt_q  <= '0;
                        state_q     <= HUNT;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= HUNT;
                end
            endcase
        end
    end

    sym_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .push_i      (push),
        .push_data_i (complete_word),
        .pop_i       (pop),
        .head_o      (out_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .fill_o      (fill)
    );

endmodule

// File: tb/tb_sym_deframer.sv
// Self-checking bench for sym_deframer: directed scenarios plus randomized traffic against a queue-based model.
module tb_sym_deframer;
    import sym_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int TMO    = 15;
`ifdef SYM_DEFRAMER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int N = DATA_W + PAR;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  in_sym = 2'b00;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic [2:0]  fill;
    logic        frame_err;
    logic        overflow;

    int checks = 0;
    int failures = 0;

    // Behavioural model: pending bits of the current word, idle run length, queued words.
    int         m_bits[$];
    int         m_idle;
    logic [7:0] m_q[$];
    logic       m_ovf;
    logic       m_ferr;

    always #5 clk = ~clk;

    sym_deframer #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .IDLE_TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in_sym),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fill      (fill),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    task automatic model_clear();
        m_bits.delete();
        m_idle = 0;
        m_q.delete();
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
    endtask

    // Drive one symbol for one clock, advance the model, return 1 time unit after the edge.
    task automatic cycle(input logic [1:0] s, input logic rdy);
        int         sz0;
        logic       pop;
        logic       have;
        logic [7:0] w;
        in_sym    = s;
        out_ready = rdy;
        sz0    = m_q.size();
        pop    = (sz0 > 0) && rdy;
        have   = 1'b0;
        m_ferr = 1'b0;
        w      = '0;
        if (s == SYM_RSVD) begin
            m_ferr = 1'b1;
            m_bits.delete();
            m_idle = 0;
        end else if (s == SYM_IDLE) begin
            if (m_bits.size() > 0) begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_ferr = 1'b1;
                    m_bits.delete();
                    m_idle = 0;
                end
            end
        end else begin
            m_bits.push_back(int'(s[0]));
            m_idle = 0;
            if (m_bits.size() == N) begin
                for (int i = 0; i < DATA_W; i++) w[i] = (m_bits[i] != 0);
                if (PAR == 0) have = 1'b1;
                else if (m_bits[DATA_W] == int'(^w)) have = 1'b1;
                else m_ferr = 1'b1;
                m_bits.delete();
            end
        end
        if (pop) void'(m_q.pop_front());
        if (have) begin
            if (sz0 < DEPTH || pop) m_q.push_back(w);
            else m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w, input logic rdy, input logic last_rdy);
        for (int i = 0; i < N; i++) begin
            if (i < DATA_W) cycle({1'b1, w[i]}, (i == N - 1) ? last_rdy : rdy);
            else cycle({1'b1, ^w}, last_rdy);
        end
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        model_clear();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", out_data); end
        checks++; if (fill !== 3'd0) begin failures++; $display("FAIL reset_fill: got %0d expected 0", fill); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
        in_sym    = SYM_IDLE;
        out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (fill !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_idle: got fill=%0d valid=%b expected 0/0", fill, out_valid); end
    endtask

    task automatic test_basic();
        logic [1:0] syms [8];
        syms = '{2'b10, 2'b11, 2'b10, 2'b10, 2'b11, 2'b10, 2'b11, 2'b11};
        do_reset();
        for (int i = 0; i < 7; i++) cycle(syms[i], 1'b0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid: got %b expected 0", out_valid); end
        cycle(syms[7], 1'b0);
        if (PAR != 0) cycle(SYM_D0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== 8'hD2) begin failures++; $display("FAIL basic_data: got %h expected d2", out_data); end
        checks++; if (fill !== 3'd1) begin failures++; $display("FAIL basic_fill: got %0d expected 1", fill); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL basic_ferr: got %b expected 0", frame_err); end
        cycle(SYM_IDLE, 1'b0);
        cycle(SYM_IDLE, 1'b0);
        checks++; if (out_data !== 8'hD2 || out_valid !== 1'b1) begin failures++; $display("FAIL basic_hold: got %h/%b expected d2/1", out_data, out_valid); end
        cycle(SYM_IDLE, 1'b1);
        checks++; if (out_valid !== 1'b0 || fill !== 3'd0) begin failures++; $display("FAIL basic_pop: got valid=%b fill=%0d expected 0/0", out_valid, fill); end
    endtask

    task automatic test_overflow();
        logic [7:0] w [5];
        do_reset();
        for (int i = 0; i < 5; i++) w[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) send_word(w[i], 1'b0, 1'b0);
        checks++; if (fill !== 3'd4 || overflow !== 1'b0) begin failures++; $display("FAIL ovf_full: got fill=%0d ovf=%b expected 4/0", fill, overflow); end
        send_word(w[4], 1'b0, 1'b0);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        checks++; if (fill !== 3'd4) begin failures++; $display("FAIL ovf_fill: got %0d expected 4", fill); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_data !== w[i]) begin failures++; $display("FAIL ovf_drain%0d: got %h expected %h", i, out_data, w[i]); end
            cycle(SYM_IDLE, 1'b1);
        end
        checks++; if (fill !== 3'd0 || overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got fill=%0d ovf=%b expected 0/1", fill, overflow); end
        do_reset();
    endtask

    task automatic test_full_push_pop();
        logic [7:0] w [5];
        do_reset();
        for (int i = 0; i < 5; i++) w[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) send_word(w[i], 1'b0, 1'b0);
        send_word(w[4], 1'b0, 1'b1);
        checks++; if (fill !== 3'd4) begin failures++; $display("FAIL fpp_fill: got %0d expected 4", fill); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fpp_ovf: got %b expected 0", overflow); end
        for (int i = 1; i < 5; i++) begin
            checks++; if (out_data !== w[i]) begin failures++; $display("FAIL fpp_drain%0d: got %h expected %h", i, out_data, w[i]); end
            cycle(SYM_IDLE, 1'b1);
        end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fpp_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, b, c;
        a = 8'h3C; b = 8'hA5; c = 8'h81;
        do_reset();
        send_word(a, 1'b0, 1'b0);
        send_word(b, 1'b0, 1'b1);
        checks++; if (fill !== 3'd1 || out_data !== b) begin failures++; $display("FAIL b2b_swap: got fill=%0d data=%h expected 1/%h", fill, out_data, b); end
        send_word(c, 1'b0, 1'b0);
        checks++; if (fill !== 3'd2 || out_data !== b) begin failures++; $display("FAIL b2b_fill: got fill=%0d data=%h expected 2/%h", fill, out_data, b); end
        cycle(SYM_IDLE, 1'b1);
        checks++; if (out_data !== c || fill !== 3'd1) begin failures++; $display("FAIL b2b_order: got %h fill=%0d expected %h/1", out_data, fill, c); end
    endtask

    task automatic test_timeout();
        logic [7:0] w;
        w = 8'hD2;
        do_reset();
        for (int i = 0; i < 3; i++) cycle({1'b1, w[i]}, 1'b0);
        for (int i = 0; i < TMO - 1; i++) cycle(SYM_IDLE, 1'b0);
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL tmo_early: got %b expected 0", frame_err); end
        cycle(SYM_IDLE, 1'b0);
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL tmo_pulse: got %b expected 1", frame_err); end
        checks++; if (fill !== 3'd0) begin failures++; $display("FAIL tmo_nopush: got %0d expected 0", fill); end
        cycle(SYM_IDLE, 1'b0);
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL tmo_oneshot: got %b expected 0", frame_err); end
        send_word(w, 1'b0, 1'b0);
        checks++; if (out_data !== 8'hD2 || fill !== 3'd1) begin failures++; $display("FAIL tmo_recover: got %h fill=%0d expected d2/1", out_data, fill); end
        cycle(SYM_IDLE, 1'b1);
        w = 8'h5B;
        for (int i = 0; i < 3; i++) cycle({1'b1, w[i]}, 1'b0);
        for (int i = 0; i < TMO - 1; i++) cycle(SYM_IDLE, 1'b0);
        for (int i = 3; i < DATA_W; i++) cycle({1'b1, w[i]}, 1'b0);
        if (PAR != 0) cycle({1'b1, ^w}, 1'b0);
        checks++; if (out_data !== 8'h5B || fill !== 3'd1) begin failures++; $display("FAIL tmo_boundary: got %h fill=%0d expected 5b/1", out_data, fill); end
    endtask

    task automatic test_rsvd();
        do_reset();
        cycle(SYM_D0, 1'b0);
        cycle(SYM_D1, 1'b0);
        cycle(SYM_RSVD, 1'b0);
        checks++; if (frame_err !== 1'b1 || fill !== 3'd0) begin failures++; $display("FAIL rsvd_mid: got ferr=%b fill=%0d expected 1/0", frame_err, fill); end
        cycle(SYM_IDLE, 1'b0);
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL rsvd_oneshot: got %b expected 0", frame_err); end
        cycle(SYM_RSVD, 1'b0);
        checks++; if (frame_err !== 1'b1 || fill !== 3'd0) begin failures++; $display("FAIL rsvd_hunt: got ferr=%b fill=%0d expected 1/0", frame_err, fill); end
        send_word(8'hD2, 1'b0, 1'b0);
        checks++; if (out_data !== 8'hD2 || fill !== 3'd1 || frame_err !== 1'b0) begin failures++; $display("FAIL rsvd_recover: got %h fill=%0d ferr=%b expected d2/1/0", out_data, fill, frame_err); end
    endtask

`ifdef SYM_DEFRAMER_PARITY_EN
    task automatic test_parity();
        logic [7:0] w;
        w = 8'hD2;
        do_reset();
        for (int i = 0; i < DATA_W; i++) cycle({1'b1, w[i]}, 1'b0);
        cycle(SYM_D0, 1'b0);
        checks++; if (fill !== 3'd1 || frame_err !== 1'b0) begin failures++; $display("FAIL par_good: got fill=%0d ferr=%b expected 1/0", fill, frame_err); end
        for (int i = 0; i < DATA_W; i++) cycle({1'b1, w[i]}, 1'b0);
        cycle(SYM_D1, 1'b0);
        checks++; if (fill !== 3'd1 || frame_err !== 1'b1) begin failures++; $display("FAIL par_bad: got fill=%0d ferr=%b expected 1/1", fill, frame_err); end
    endtask
`endif

    task automatic test_reset_midword();
        do_reset();
        send_word(8'h77, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(SYM_D1, 1'b0);
        do_reset();
        send_word(8'hD2, 1'b0, 1'b0);
        checks++; if (out_data !== 8'hD2 || fill !== 3'd1) begin failures++; $display("FAIL rst_mid_clean: got %h fill=%0d expected d2/1", out_data, fill); end
    endtask

    task automatic test_random();
        int         r;
        int         burst;
        logic [1:0] s;
        logic       rdy;
        burst = 0;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 99));
            if (burst > 0) begin
                s = SYM_IDLE;
                burst--;
            end else if (r < 2) begin
                s = SYM_IDLE;
                burst = int'($urandom_range(TMO - 2, TMO + 1));
            end else if (r < 5) s = SYM_RSVD;
            else if (r < 15) s = SYM_IDLE;
            else s = {1'b1, 1'($urandom)};
            rdy = ($urandom_range(0, 99) < 45);
            cycle(s, rdy);
            checks++; if (out_valid !== (m_q.size() != 0)) begin failures++; $display("FAIL rnd_valid@%0d: got %b expected %b", n, out_valid, m_q.size() != 0); end
            checks++; if (fill !== 3'(m_q.size())) begin failures++; $display("FAIL rnd_fill@%0d: got %0d expected %0d", n, fill, m_q.size()); end
            if (m_q.size() != 0) begin
                checks++; if (out_data !== m_q[0]) begin failures++; $display("FAIL rnd_data@%0d: got %h expected %h", n, out_data, m_q[0]); end
            end
            checks++; if (frame_err !== m_ferr) begin failures++; $display("FAIL rnd_ferr@%0d: got %b expected %b", n, frame_err, m_ferr); end
            checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL rnd_ovf@%0d: got %b expected %b", n, overflow, m_ovf); end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_timeout();
        test_rsvd();
`ifdef SYM_DEFRAMER_PARITY_EN
        test_parity();
`endif
        test_reset_midword();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
